clause_feeder: RTL and testbench

CLAUSE_FEEDER -- requirements
Module: clause_feeder

---
 rtl/checker_pkg.sv | 22 ++
 rtl/clause_memory.sv | 34 +++
 rtl/clause_feeder.sv | 158 +++++++++++++++
 tb/tb_clause_feeder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// Shared definitions for the clause feeder: FSM state encoding, default
// parameter values and the 2-bit boolean-coefficient encoding.
package checker_pkg;

  localparam int DEF_MAX_BIT_WIDTH_OF_VARIABLES_INDEX = 7;
  localparam int DEF_BIT_WIDTH_OF_INTEGER             = 8;
  localparam int DEF_MAX_BIT_WIDTH_OF_CLAUSES_INDEX   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Per-variable boolean coefficient codes, shared with the checker.
  localparam logic [1:0] BOOL_DONT_CARE = 2'b00;
  localparam logic [1:0] BOOL_POSITIVE  = 2'b01;
  localparam logic [1:0] BOOL_NEGATIVE  = 2'b10;
  localparam logic [1:0] BOOL_RESERVED  = 2'b11;

endpackage

// File: rtl/clause_memory.sv
// Clause storage: one entry per clause slot, synchronous write and
// combinational read so the issued clause appears in the same cycle.
module clause_memory
  import checker_pkg::*;
#(
  parameter int IDX_W  = DEF_MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
  parameter int BOOL_W = 2 * (2 ** DEF_MAX_BIT_WIDTH_OF_VARIABLES_INDEX),
  parameter int INT_W  = ((2 ** DEF_MAX_BIT_WIDTH_OF_VARIABLES_INDEX) + 1) * DEF_BIT_WIDTH_OF_INTEGER
) (
  input  logic              in_clk,
  input  logic              in_we,
  input  logic [IDX_W-1:0]  in_waddr,
  input  logic [BOOL_W-1:0] in_wbool,
  input  logic [INT_W-1:0]  in_wint,
  input  logic [IDX_W-1:0]  in_raddr,
  output logic [BOOL_W-1:0] out_rbool,
  output logic [INT_W-1:0]  out_rint
);

  logic [BOOL_W-1:0] bool_mem [2**IDX_W];
  logic [INT_W-1:0]  int_mem  [2**IDX_W];

  // Contents deliberately survive reset.
  always_ff @(posedge in_clk) begin
    if (in_we) begin
      bool_mem[in_waddr] <= in_wbool;
      int_mem[in_waddr]  <= in_wint;
    end
  end

  assign out_rbool = bool_mem[in_raddr];
  assign out_rint  = int_mem[in_raddr];

endmodule

// File: rtl/clause_feeder.sv
// Streams stored clauses to an external checker one per cycle and tallies
// the checker's one-cycle-delayed verdicts into pass results.
module clause_feeder
  import checker_pkg::*;
#(
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX = DEF_MAX_BIT_WIDTH_OF_VARIABLES_INDEX,
  parameter int BIT_WIDTH_OF_INTEGER             = DEF_BIT_WIDTH_OF_INTEGER,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX   = DEF_MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int NV = 2 ** MAX_BIT_WIDTH_OF_VARIABLES_INDEX,
  localparam int W  = BIT_WIDTH_OF_INTEGER,
  localparam int C  = MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int BW = 2 * NV,
  localparam int IW = (NV + 1) * W
) (
  input  logic          in_clk,
  input  logic          in_reset,
  input  logic          in_load_valid,
  input  logic [C-1:0]  in_load_index,
  input  logic [BW-1:0] in_load_bool_coeff,
  input  logic [IW-1:0] in_load_int_coeff,
  input  logic [C:0]    in_number_of_clauses,
  input  logic          in_start,
  input  logic          in_clause_is_satisfied,
  output logic [BW-1:0] out_bool_coeff,
  output logic [IW-1:0] out_int_coeff,
  output logic          out_check_enable,
  output logic          out_load_ready,
  output logic          out_busy,
  output logic          out_done,
  output logic [C:0]    out_unsat_count,
  output logic [C-1:0]  out_first_unsat_index,
  output logic          out_all_satisfied
);

  localparam logic [C:0] NC_CNT = (C+1)'(2 ** C);

  state_t       state_q, state_d;
  logic [C-1:0] idx_q, idx_d;
  logic [C:0]   n_q, n_d;
  logic [C:0]   unsat_q, unsat_d;
  logic [C-1:0] first_q, first_d;
  logic         found_q, found_d;
  logic         pend_q, pend_d;
  logic [C-1:0] pend_idx_q, pend_idx_d;
  logic         all_sat_q, all_sat_d;

  logic [C:0]   n_sel;
  logic         load_we;
  logic [BW-1:0] rd_bool;
  logic [IW-1:0] rd_int;

  assign n_sel   = (in_number_of_clauses > NC_CNT) ? NC_CNT : in_number_of_clauses;
  assign load_we = (state_q == ST_IDLE) && in_load_valid;

  clause_memory #(
    .IDX_W  (C),
    .BOOL_W (BW),
    .INT_W  (IW)
  ) u_mem (
    .in_clk    (in_clk),
    .in_we     (load_we),
    .in_waddr  (in_load_index),
    .in_wbool  (in_load_bool_coeff),
    .in_wint   (in_load_int_coeff),
    .in_raddr  (idx_q),
    .out_rbool (rd_bool),
    .out_rint  (rd_int)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    unsat_d    = unsat_q;
    first_d    = first_q;
    found_d    = found_q;
    pend_d     = 1'b0;
    pend_idx_d = idx_q;
    all_sat_d  = all_sat_q;

    // Verdict for the clause issued in the previous cycle.
    if (pend_q && !in_clause_is_satisfied) begin
      unsat_d = unsat_q + 1'b1;
      if (!found_q) begin
        found_d = 1'b1;
        first_d = pend_idx_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          n_d       = n_sel;
          idx_d     = '0;
          unsat_d   = '0;
          first_d   = '0;
          found_d   = 1'b0;
          all_sat_d = (n_sel == '0);
          state_d   = (n_sel == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        pend_d     = 1'b1;
        pend_idx_d = idx_q;
        if ({1'b0, idx_q} == n_q - 1'b1) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        all_sat_d = (unsat_d == '0);
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      unsat_q    <= '0;
      first_q    <= '0;
      found_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      all_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      unsat_q    <= unsat_d;
      first_q    <= first_d;
      found_q    <= found_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      all_sat_q  <= all_sat_d;
    end
  end

  assign out_check_enable      = (state_q == ST_ISSUE);
  assign out_bool_coeff        = out_check_enable ? rd_bool : '0;
  assign out_int_coeff         = out_check_enable ? rd_int : '0;
  assign out_load_ready        = (state_q == ST_IDLE);
  assign out_busy              = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign out_done              = (state_q == ST_DONE);
  assign out_unsat_count       = unsat_q;
  assign out_first_unsat_index = first_q;
  assign out_all_satisfied     = all_sat_q;

endmodule

// File: tb/tb_clause_feeder.sv
// Scoreboard bench for clause_feeder (NV=4, W=8, NC=4) with a scripted checker model.
module tb_clause_feeder;

  localparam int VB = 2;
  localparam int WI = 8;
  localparam int CB = 2;
  localparam int BW = 2 * (2 ** VB);
  localparam int IW = ((2 ** VB) + 1) * WI;

  typedef struct {
    logic [BW-1:0] b;
    logic [IW-1:0] i;
    int            cyc;
  } issue_t;

  typedef struct {
    int unsat;
    int first;
    int all;
    int cyc;
  } done_t;

  logic          clk = 1'b0;
  logic          in_reset = 1'b1;
  logic          in_load_valid = 1'b0;
  logic [CB-1:0] in_load_index = '0;
  logic [BW-1:0] in_load_bool_coeff = '0;
  logic [IW-1:0] in_load_int_coeff = '0;
  logic [CB:0]   in_number_of_clauses = '0;
  logic          in_start = 1'b0;
  logic          in_clause_is_satisfied = 1'b0;
  logic [BW-1:0] out_bool_coeff;
  logic [IW-1:0] out_int_coeff;
  logic          out_check_enable, out_load_ready, out_busy, out_done;
  logic [CB:0]   out_unsat_count;
  logic [CB-1:0] out_first_unsat_index;
  logic          out_all_satisfied;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic en_seen = 1'b0;

  issue_t exp_issue[$];
  done_t  exp_done[$];
  bit     script[$];
  logic [BW-1:0] mem_b [4];
  logic [IW-1:0] mem_i [4];

  clause_feeder #(
    .MAX_BIT_WIDTH_OF_VARIABLES_INDEX (VB),
    .BIT_WIDTH_OF_INTEGER             (WI),
    .MAX_BIT_WIDTH_OF_CLAUSES_INDEX   (CB)
  ) dut (
    .in_clk                 (clk),
    .in_reset               (in_reset),
    .in_load_valid          (in_load_valid),
    .in_load_index          (in_load_index),
    .in_load_bool_coeff     (in_load_bool_coeff),
    .in_load_int_coeff      (in_load_int_coeff),
    .in_number_of_clauses   (in_number_of_clauses),
    .in_start               (in_start),
    .in_clause_is_satisfied (in_clause_is_satisfied),
    .out_bool_coeff         (out_bool_coeff),
    .out_int_coeff          (out_int_coeff),
    .out_check_enable       (out_check_enable),
    .out_load_ready         (out_load_ready),
    .out_busy               (out_busy),
    .out_done               (out_done),
    .out_unsat_count        (out_unsat_count),
    .out_first_unsat_index  (out_first_unsat_index),
    .out_all_satisfied      (out_all_satisfied)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] gen_b(input int s, input int g);
    gen_b = BW'(8'h1B * (s + 1) + 8'h35 * g);
  endfunction

  function automatic logic [IW-1:0] gen_i(input int s, input int g);
    gen_i = 40'h10_2030_4050 + IW'(s) * 40'h01_0101_0101 + IW'(g) * 40'h11_0000_0011;
  endfunction

  // Checker model: answers each enable cycle in the following cycle.
  initial forever begin
    bit pending;
    @(posedge clk);
    pending = en_seen;
    #1;
    if (pending) begin
      if (script.size() > 0) in_clause_is_satisfied = script.pop_front();
      else                   in_clause_is_satisfied = 1'b1;
    end
  end

  // Monitor: compares every presented clause and every done pulse against the scoreboard.
  initial forever begin
    @(negedge clk);
    en_seen = out_check_enable;
    if (out_check_enable) begin
      if (exp_issue.size() == 0) begin
        check("unexpected_enable", 64'(out_check_enable), 64'd0);
      end else begin
        issue_t e;
        e = exp_issue.pop_front();
        check("issue_bool", 64'(out_bool_coeff), 64'(e.b));
        check("issue_int", 64'(out_int_coeff), 64'(e.i));
        check("issue_cycle", 64'(cyc - start_cyc), 64'(e.cyc));
        $display("issue: cycle %0d bool=%0h int=%0h", cyc - start_cyc, out_bool_coeff, out_int_coeff);
      end
    end else begin
      check("idle_coeff_zero", {out_bool_coeff, out_int_coeff[IW-1:8]}, 64'd0);
    end
    if (out_done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 64'(out_done), 64'd0);
      end else begin
        done_t d;
        d = exp_done.pop_front();
        check("done_cycle", 64'(cyc - start_cyc), 64'(d.cyc));
        check("unsat_count", 64'(out_unsat_count), 64'(d.unsat));
        check("first_unsat_index", 64'(out_first_unsat_index), 64'(d.first));
        check("all_satisfied", 64'(out_all_satisfied), 64'(d.all));
        $display("done: cycle %0d unsat=%0d first=%0d all=%0d", cyc - start_cyc,
                 out_unsat_count, out_first_unsat_index, out_all_satisfied);
      end
    end
  end

  task automatic load(input int s, input int g);
    in_load_valid = 1'b1;
    in_load_index = CB'(s);
    in_load_bool_coeff = gen_b(s, g);
    in_load_int_coeff = gen_i(s, g);
    mem_b[s] = gen_b(s, g);
    mem_i[s] = gen_i(s, g);
    tick();
    in_load_valid = 1'b0;
  endtask

  task automatic push_pass(input int n, input int unsat, input int first, input int all);
    int eff;
    done_t d;
    eff = (n > 4) ? 4 : n;
    for (int k = 0; k < eff; k++) begin
      issue_t e;
      e.b = mem_b[k];
      e.i = mem_i[k];
      e.cyc = k + 1;
      exp_issue.push_back(e);
    end
    d.unsat = unsat;
    d.first = first;
    d.all = all;
    d.cyc = (eff == 0) ? 1 : eff + 2;
    exp_done.push_back(d);
  endtask

  task automatic start_pass(input int n);
    in_start = 1'b1;
    in_number_of_clauses = (CB+1)'(n);
    tick();
    in_start = 1'b0;
    start_cyc = cyc - 1;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_issue.size() != 0 || exp_done.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (exp_issue.size() != 0 || exp_done.size() != 0) begin
      check("timeout_pending", 64'(exp_issue.size() + exp_done.size()), 64'd0);
      exp_issue.delete();
      exp_done.delete();
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_load_ready", 64'(out_load_ready), 64'd1);
    check("rst_busy", 64'(out_busy), 64'd0);
    check("rst_done", 64'(out_done), 64'd0);
    check("rst_enable", 64'(out_check_enable), 64'd0);
    check("rst_results", {out_unsat_count, out_first_unsat_index, out_all_satisfied}, 64'd0);
    in_reset = 1'b0;
    tick();

    for (int s = 0; s < 4; s++) load(s, 0);

    // Three clauses, middle one unsatisfied.
    script.delete(); script.push_back(1); script.push_back(0); script.push_back(1);
    push_pass(3, 1, 1, 0);
    start_pass(3);
    wait_drain(40);
    repeat (3) tick();
    check("hold_unsat", 64'(out_unsat_count), 64'd1);
    check("hold_first", 64'(out_first_unsat_index), 64'd1);
    check("hold_all", 64'(out_all_satisfied), 64'd0);
    check("hold_ready", 64'(out_load_ready), 64'd1);

    // Empty pass.
    script.delete();
    push_pass(0, 0, 0, 1);
    start_pass(0);
    wait_drain(40);

    // Request beyond capacity is clamped to four.
    script.delete(); repeat (4) script.push_back(1);
    push_pass(6, 0, 0, 1);
    start_pass(6);
    wait_drain(40);

    // Reset in cycle 2 of a four-clause pass.
    script.delete(); repeat (4) script.push_back(1);
    for (int k = 0; k < 2; k++) begin
      issue_t e;
      e.b = mem_b[k];
      e.i = mem_i[k];
      e.cyc = k + 1;
      exp_issue.push_back(e);
    end
    start_pass(4);
    tick();
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
    check("abort_busy", 64'(out_busy), 64'd0);
    check("abort_enable", 64'(out_check_enable), 64'd0);
    check("abort_ready", 64'(out_load_ready), 64'd1);
    check("abort_unsat", 64'(out_unsat_count), 64'd0);
    repeat (5) tick();
    check("abort_issues_seen", 64'(exp_issue.size()), 64'd0);
    exp_issue.delete();

    load(0, 2);
    load(1, 2);
    script.delete(); script.push_back(0); script.push_back(0);
    push_pass(2, 2, 0, 0);
    start_pass(2);
    wait_drain(40);

    // Load and restart while busy are both ignored.
    script.delete(); repeat (4) script.push_back(1);
    push_pass(4, 0, 0, 1);
    start_pass(4);
    in_load_valid = 1'b1;
    in_load_index = '0;
    in_load_bool_coeff = gen_b(0, 7);
    in_load_int_coeff = gen_i(0, 7);
    in_start = 1'b1;
    in_number_of_clauses = 3'd1;
    tick();
    in_load_valid = 1'b0;
    in_start = 1'b0;
    wait_drain(40);
    repeat (3) tick();
    check("stray_start_ignored", 64'(out_busy), 64'd0);
    script.delete(); script.push_back(1);
    push_pass(1, 0, 0, 1);
    start_pass(1);
    wait_drain(40);

    // Load slot 2 in the same cycle as start.
    mem_b[2] = gen_b(2, 9);
    mem_i[2] = gen_i(2, 9);
    script.delete(); script.push_back(1); script.push_back(0); script.push_back(0);
    push_pass(3, 2, 1, 0);
    in_load_valid = 1'b1;
    in_load_index = 2'd2;
    in_load_bool_coeff = gen_b(2, 9);
    in_load_int_coeff = gen_i(2, 9);
    start_pass(3);
    in_load_valid = 1'b0;
    wait_drain(40);

    repeat (3) tick();
    check("final_queues_empty", 64'(exp_issue.size() + exp_done.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
